// File: rtl/mips_multicycle_control_if.sv
`default_nettype none
// ============================================================================
// Module   : mips_multicycle_control_if
// Brief    : Opcode/handshake inputs and datapath controls of the MIPS control FSM
// Revision : 1.0
// ============================================================================
interface mips_multicycle_control_if #(
  parameter int CNT_W = 16
);
  logic [5:0]       opcode;
  logic             mem_ready;
  logic             pc_write;
  logic             pc_write_cond;
  logic             i_or_d;
  logic             mem_read;
  logic             mem_write;
  logic             ir_write;
  logic             mem_to_reg;
  logic             reg_dst;
  logic             reg_write;
  logic             alu_src_a;
  logic [1:0]       alu_src_b;
  logic [1:0]       alu_op;
  logic [1:0]       pc_source;
  logic [3:0]       state_out;
  logic             illegal_op;
  logic             bus_error;
  logic [CNT_W-1:0] instr_count;

  modport master (
    input  opcode, mem_ready,
    output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, state_out, illegal_op, bus_error, instr_count
  );

  modport slave (
    output opcode, mem_ready,
    input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, state_out, illegal_op, bus_error, instr_count
  );
endinterface
`default_nettype wire

// File: rtl/mips_multicycle_control.sv
`default_nettype none
// ============================================================================
// Module   : mips_multicycle_control
// Brief    : Multi-cycle MIPS main control FSM with memory wait watchdog
// Revision : 1.0
// ============================================================================
module mips_multicycle_control #(
  parameter int WAIT_LIMIT = 15,
  parameter int CNT_W      = 16
) (
  input  wire logic                 clk,
  input  wire logic                 rst_n,
  mips_multicycle_control_if.master bus
);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_MEM_ADR   = 4'd3,
    S_MEM_READ  = 4'd4,
    S_MEM_WB    = 4'd5,
    S_MEM_WRITE = 4'd6,
    S_EXECUTE   = 4'd7,
    S_ALU_WB    = 4'd8,
    S_BRANCH    = 4'd9,
    S_JUMP      = 4'd10,
    S_ADDI_EXEC = 4'd11,
    S_ADDI_WB   = 4'd12
  } state_t;

  localparam logic [5:0] c_op_rtype = 6'b000000;
  localparam logic [5:0] c_op_lw    = 6'b100011;
  localparam logic [5:0] c_op_sw    = 6'b101011;
  localparam logic [5:0] c_op_beq   = 6'b000100;
  localparam logic [5:0] c_op_j     = 6'b000010;
  localparam logic [5:0] c_op_addi  = 6'b001000;
  // Last wait count before the watchdog fires: reaching WAIT_LIMIT aborts.
  localparam logic [7:0] c_wait_last = 8'(WAIT_LIMIT - 1);

  state_t           r_state;
  state_t           w_next;
  logic [7:0]       r_wait;
  logic             r_illegal_op;
  logic             r_bus_error;
  logic [CNT_W-1:0] r_instr_count;
  logic             w_mem_state;
  logic             w_timeout;
  logic             w_retire;
  logic             w_illegal;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_wait        <= 8'd0;
      r_illegal_op  <= 1'b0;
      r_bus_error   <= 1'b0;
      r_instr_count <= '0;
    end else begin
      r_state <= w_next;
      // Any exit, entry or abort leaves the counter at zero.
      if (w_mem_state && !bus.mem_ready && !w_timeout)
        r_wait <= r_wait + 8'd1;
      else
        r_wait <= 8'd0;
      if (w_illegal)
        r_illegal_op <= 1'b1;
      if (w_timeout)
        r_bus_error <= 1'b1;
      if (w_retire)
        r_instr_count <= r_instr_count + 1'b1;
    end
  end

  always_comb begin
    w_next            = r_state;
    w_mem_state       = 1'b0;
    w_timeout         = 1'b0;
    w_retire          = 1'b0;
    w_illegal         = 1'b0;
    bus.pc_write      = 1'b0;
    bus.pc_write_cond = 1'b0;
    bus.i_or_d        = 1'b0;
    bus.mem_read      = 1'b0;
    bus.mem_write     = 1'b0;
    bus.ir_write      = 1'b0;
    bus.mem_to_reg    = 1'b0;
    bus.reg_dst       = 1'b0;
    bus.reg_write     = 1'b0;
    bus.alu_src_a     = 1'b0;
    bus.alu_src_b     = 2'b00;
    bus.alu_op        = 2'b00;
    bus.pc_source     = 2'b00;
    case (r_state)
      S_IDLE: w_next = S_FETCH;
      S_FETCH: begin
        w_mem_state   = 1'b1;
        bus.mem_read  = 1'b1;
        bus.alu_src_b = 2'b01;
        // IR and PC load only on the cycle the fetch actually completes.
        bus.ir_write  = bus.mem_ready;
        bus.pc_write  = bus.mem_ready;
        if (bus.mem_ready) begin
          w_next = S_DECODE;
        end else if (r_wait == c_wait_last) begin
          w_timeout = 1'b1;
          w_next    = S_FETCH;
        end
      end
      S_DECODE: begin
        bus.alu_src_b = 2'b11;
        case (bus.opcode)
          c_op_lw, c_op_sw: w_next = S_MEM_ADR;
          c_op_rtype:       w_next = S_EXECUTE;
          c_op_beq:         w_next = S_BRANCH;
          c_op_j:           w_next = S_JUMP;
          c_op_addi:        w_next = S_ADDI_EXEC;
          default: begin
            w_illegal = 1'b1;
            w_next    = S_FETCH;
          end
        endcase
      end
      S_MEM_ADR: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 2'b10;
        if (bus.opcode == c_op_lw)
          w_next = S_MEM_READ;
        else if (bus.opcode == c_op_sw)
          w_next = S_MEM_WRITE;
        else
          w_next = S_FETCH;
      end
      S_MEM_READ: begin
        w_mem_state  = 1'b1;
        bus.mem_read = 1'b1;
        bus.i_or_d   = 1'b1;
        if (bus.mem_ready) begin
          w_next = S_MEM_WB;
        end else if (r_wait == c_wait_last) begin
          w_timeout = 1'b1;
          w_next    = S_FETCH;
        end
      end
      S_MEM_WB: begin
        bus.reg_write  = 1'b1;
        bus.mem_to_reg = 1'b1;
        w_retire       = 1'b1;
        w_next         = S_FETCH;
      end
      S_MEM_WRITE: begin
        w_mem_state   = 1'b1;
        bus.mem_write = 1'b1;
        bus.i_or_d    = 1'b1;
        if (bus.mem_ready) begin
          w_retire = 1'b1;
          w_next   = S_FETCH;
        end else if (r_wait == c_wait_last) begin
          w_timeout = 1'b1;
          w_next    = S_FETCH;
        end
      end
      S_EXECUTE: begin
        bus.alu_src_a = 1'b1;
        bus.alu_op    = 2'b10;
        w_next        = S_ALU_WB;
      end
      S_ALU_WB: begin
        bus.reg_write = 1'b1;
        bus.reg_dst   = 1'b1;
        w_retire      = 1'b1;
        w_next        = S_FETCH;
      end
      S_BRANCH: begin
        bus.alu_src_a     = 1'b1;
        bus.alu_op        = 2'b01;
        bus.pc_write_cond = 1'b1;
        bus.pc_source     = 2'b01;
        w_retire          = 1'b1;
        w_next            = S_FETCH;
      end
      S_JUMP: begin
        bus.pc_write  = 1'b1;
        bus.pc_source = 2'b10;
        w_retire      = 1'b1;
        w_next        = S_FETCH;
      end
      S_ADDI_EXEC: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 2'b10;
        w_next        = S_ADDI_WB;
      end
      S_ADDI_WB: begin
        bus.reg_write = 1'b1;
        w_retire      = 1'b1;
        w_next        = S_FETCH;
      end
      default: w_next = S_FETCH;
    endcase
  end

  assign bus.state_out   = r_state;
  assign bus.illegal_op  = r_illegal_op;
  assign bus.bus_error   = r_bus_error;
  assign bus.instr_count = r_instr_count;

endmodule
`default_nettype wire

// File: tb/tb_mips_multicycle_control.sv
`default_nettype none
// ============================================================================
// Module   : tb_mips_multicycle_control
// Brief    : Directed self-checking bench for the multi-cycle MIPS control FSM
// Revision : 1.0
// ============================================================================
module tb_mips_multicycle_control;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  mips_multicycle_control_if #(.CNT_W(16)) bus ();

  mips_multicycle_control #(
    .WAIT_LIMIT(15),
    .CNT_W     (16)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Outputs settle 2 time units after the active edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    total         = 0;
    bad           = 0;
    rst_n         = 1'b0;
    bus.opcode    = 6'b000000;
    bus.mem_ready = 1'b1;

    // Reset state
    tick();
    tick();
    chk("rst_state", 32'(bus.state_out), 32'd0);
    chk("rst_mem_read", 32'(bus.mem_read), 32'd0);
    chk("rst_ir_write", 32'(bus.ir_write), 32'd0);
    chk("rst_pc_write", 32'(bus.pc_write), 32'd0);
    chk("rst_count", 32'(bus.instr_count), 32'd0);
    chk("rst_flags", {30'd0, bus.illegal_op, bus.bus_error}, 32'd0);

    // R-type: 0,1,2,7,8,1
    rst_n = 1'b1;
    #1;
    chk("idle_after_release", 32'(bus.state_out), 32'd0);
    tick();
    chk("r_fetch_state", 32'(bus.state_out), 32'd1);
    chk("r_fetch_ctl", {26'd0, bus.mem_read, bus.ir_write, bus.pc_write, bus.i_or_d, bus.alu_src_b},
        {26'd0, 1'b1, 1'b1, 1'b1, 1'b0, 2'b01});
    tick();
    chk("r_decode_state", 32'(bus.state_out), 32'd2);
    chk("r_decode_srcb", 32'(bus.alu_src_b), 32'd3);
    tick();
    chk("r_exec_state", 32'(bus.state_out), 32'd7);
    chk("r_exec_aluop", 32'(bus.alu_op), 32'd2);
    chk("r_exec_srca", 32'(bus.alu_src_a), 32'd1);
    tick();
    chk("r_wb_state", 32'(bus.state_out), 32'd8);
    chk("r_wb_ctl", {29'd0, bus.reg_write, bus.reg_dst, bus.mem_to_reg}, 32'b110);
    tick();
    chk("r_back_fetch", 32'(bus.state_out), 32'd1);
    chk("r_count", 32'(bus.instr_count), 32'd1);

    // lw with three wait cycles in MEM_READ
    bus.opcode = 6'b100011;
    tick();
    chk("lw_decode", 32'(bus.state_out), 32'd2);
    tick();
    chk("lw_memadr_state", 32'(bus.state_out), 32'd3);
    chk("lw_memadr_ctl", {29'd0, bus.alu_src_a, bus.alu_src_b}, 32'b110);
    bus.mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("lw_memread_wait", 32'(bus.state_out), 32'd4);
      chk("lw_memread_ctl", {30'd0, bus.mem_read, bus.i_or_d}, 32'b11);
    end
    tick();
    bus.mem_ready = 1'b1;
    chk("lw_memread_last", 32'(bus.state_out), 32'd4);
    tick();
    chk("lw_memwb_state", 32'(bus.state_out), 32'd5);
    chk("lw_memwb_ctl", {29'd0, bus.reg_write, bus.reg_dst, bus.mem_to_reg}, 32'b101);
    tick();
    chk("lw_back_fetch", 32'(bus.state_out), 32'd1);
    chk("lw_count", 32'(bus.instr_count), 32'd2);

    // beq
    bus.opcode = 6'b000100;
    tick();
    tick();
    chk("beq_state", 32'(bus.state_out), 32'd9);
    chk("beq_ctl", {25'd0, bus.alu_op, bus.alu_src_b, bus.pc_write_cond, bus.pc_source},
        {25'd0, 2'b01, 2'b00, 1'b1, 2'b01});
    tick();
    chk("beq_count", 32'(bus.instr_count), 32'd3);

    // j
    bus.opcode = 6'b000010;
    tick();
    tick();
    chk("j_state", 32'(bus.state_out), 32'd10);
    chk("j_ctl", {29'd0, bus.pc_write, bus.pc_source}, 32'b110);
    tick();
    chk("j_fetch", 32'(bus.state_out), 32'd1);
    chk("j_count", 32'(bus.instr_count), 32'd4);

    // addi
    bus.opcode = 6'b001000;
    tick();
    tick();
    chk("addi_exec", {24'd0, bus.state_out, 1'b0, bus.alu_src_a, bus.alu_src_b},
        {24'd0, 4'd11, 1'b0, 1'b1, 2'b10});
    tick();
    chk("addi_wb", {24'd0, bus.state_out, 1'b0, bus.reg_write, bus.reg_dst, bus.mem_to_reg},
        {24'd0, 4'd12, 1'b0, 1'b1, 1'b0, 1'b0});
    tick();
    chk("addi_count", 32'(bus.instr_count), 32'd5);

    // sw, no wait
    bus.opcode = 6'b101011;
    tick();
    tick();
    tick();
    chk("sw_state", 32'(bus.state_out), 32'd6);
    chk("sw_ctl", {29'd0, bus.mem_write, bus.i_or_d, bus.mem_read}, 32'b110);
    tick();
    chk("sw_count", 32'(bus.instr_count), 32'd6);

    // Illegal opcode
    bus.opcode = 6'b111111;
    tick();
    chk("ill_decode", 32'(bus.state_out), 32'd2);
    chk("ill_flag_pre", 32'(bus.illegal_op), 32'd0);
    tick();
    chk("ill_fetch", 32'(bus.state_out), 32'd1);
    chk("ill_flag", 32'(bus.illegal_op), 32'd1);
    chk("ill_count", 32'(bus.instr_count), 32'd6);

    // Fetch timeout: 15 wait cycles then bus_error
    bus.opcode    = 6'b000010;
    bus.mem_ready = 1'b0;
    #1;
    chk("to_irw_first", 32'(bus.ir_write), 32'd0);
    for (int i = 0; i < 14; i++) begin
      tick();
      chk("to_wait_state", {30'd0, bus.ir_write, bus.pc_write}, 32'd0);
      chk("to_wait_err", {28'd0, bus.state_out} | {31'd0, bus.bus_error}, 32'd1);
    end
    tick();
    chk("to_err", 32'(bus.bus_error), 32'd1);
    chk("to_refetch", 32'(bus.state_out), 32'd1);
    chk("to_count", 32'(bus.instr_count), 32'd6);
    chk("to_ill_held", 32'(bus.illegal_op), 32'd1);
    bus.mem_ready = 1'b1;
    tick();
    chk("to_resume", 32'(bus.state_out), 32'd2);
    tick();
    chk("to_jump", 32'(bus.state_out), 32'd10);
    tick();
    chk("to_jump_count", 32'(bus.instr_count), 32'd7);

    // Async reset mid MEM_WRITE
    bus.opcode = 6'b101011;
    tick();
    tick();
    bus.mem_ready = 1'b0;
    tick();
    chk("arst_pre_state", 32'(bus.state_out), 32'd6);
    chk("arst_pre_mw", 32'(bus.mem_write), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_mw", 32'(bus.mem_write), 32'd0);
    chk("arst_state", 32'(bus.state_out), 32'd0);
    chk("arst_count", 32'(bus.instr_count), 32'd0);
    chk("arst_flags", {30'd0, bus.illegal_op, bus.bus_error}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mips_multicycle_control.md
Name: mips_multicycle_control

Overview:
- Multi-cycle MIPS main control FSM.
- Decodes the 6-bit opcode from the instruction register and sequences each instruction through fetch, decode, execute, memory and writeback steps.
- Drives datapath mux/enable controls and the 2-bit alu_op consumed by the ALU control decoder: 00 = add, 01 = subtract, 10 = use funct field.
- Inserts wait states on a memory ready handshake, with a timeout watchdog.

Parameters:
WAIT_LIMIT, 15, max cycles a memory state may wait for mem_ready before bus_error (1..255)
CNT_W, 16, width of retired-instruction counter

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
opcode  input  6  instruction[31:26] from IR, stable from DECODE onward
mem_ready  input  1  memory completes current read/write this cycle
pc_write  output  1  unconditional PC load
pc_write_cond  output  1  PC load if ALU zero
i_or_d  output  1  memory address select: 0 = PC, 1 = ALUOut
mem_read  output  1  memory read request
mem_write  output  1  memory write request
ir_write  output  1  load instruction register
mem_to_reg  output  1  writeback select: 1 = MDR, 0 = ALUOut
reg_dst  output  1  destination select: 1 = rd, 0 = rt
reg_write  output  1  register file write enable
alu_src_a  output  1  0 = PC, 1 = A register
alu_src_b  output  2  00 = B, 01 = const 4, 10 = signext imm, 11 = signext imm << 2
alu_op  output  2  to ALU control decoder
pc_source  output  2  00 = ALU result, 01 = ALUOut, 10 = jump target
state_out  output  4  current state code (debug)
illegal_op  output  1  sticky: unsupported opcode decoded
bus_error  output  1  sticky: memory wait exceeded WAIT_LIMIT
instr_count  output  CNT_W  retired instructions, wraps modulo 2^CNT_W

Behaviour:
- Reset (async, rst_n = 0):
  - state = IDLE (0).
  - Sticky flags 0; instr_count 0; wait counter 0.
  - All control outputs 0.
  - IDLE -> FETCH unconditionally on the first clk edge after release.
- Moore outputs decoded from state. Exceptions: ir_write and pc_write in FETCH equal mem_ready (combinational gating). Any control not listed for a state is 0.
- Supported opcodes: 000000 R-type, 100011 lw, 101011 sw, 000100 beq, 000010 j, 001000 addi.
- States (code: outputs -> next):
  - FETCH (1): mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00 -> DECODE when mem_ready, else stay.
  - DECODE (2): alu_src_a=0, alu_src_b=11, alu_op=00 -> by opcode:
    - lw/sw -> MEM_ADR
    - R-type -> EXECUTE
    - beq -> BRANCH
    - j -> JUMP
    - addi -> ADDI_EXEC
    - other -> FETCH and set illegal_op
  - MEM_ADR (3): alu_src_a=1, alu_src_b=10, alu_op=00 -> MEM_READ if lw, MEM_WRITE if sw.
  - MEM_READ (4): mem_read=1, i_or_d=1 -> MEM_WB when mem_ready.
  - MEM_WB (5): reg_write=1, mem_to_reg=1, reg_dst=0 -> FETCH.
  - MEM_WRITE (6): mem_write=1, i_or_d=1 -> FETCH when mem_ready.
  - EXECUTE (7): alu_src_a=1, alu_src_b=00, alu_op=10 -> ALU_WB.
  - ALU_WB (8): reg_write=1, reg_dst=1, mem_to_reg=0 -> FETCH.
  - BRANCH (9): alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01 -> FETCH.
  - JUMP (10): pc_write=1, pc_source=10 -> FETCH.
  - ADDI_EXEC (11): alu_src_a=1, alu_src_b=10, alu_op=00 -> ADDI_WB.
  - ADDI_WB (12): reg_write=1, reg_dst=0, mem_to_reg=0 -> FETCH.
  - Codes 13-15: unreachable; if entered, next = FETCH with all outputs 0.
- Latencies, counted in cycles with mem_ready=1 on the first memory cycle:
  - beq, j: 3
  - R-type, addi, sw: 4
  - lw: 5
- Wait counter:
  - Clears on entry to FETCH, MEM_READ or MEM_WRITE.
  - Increments each cycle one of those states is held with mem_ready=0.
  - When the count reaches WAIT_LIMIT with mem_ready still 0: set bus_error, next state = FETCH. The aborted instruction does not retire; ir_write/pc_write stay 0.
  - mem_ready=1 in the same cycle the limit is reached: completes normally, no error.
- instr_count increments on the edge leaving MEM_WB, MEM_WRITE (on mem_ready), ALU_WB, BRANCH, JUMP and ADDI_WB. Illegal opcodes and timeouts do not count. Wraps from all-ones to 0.
- Sticky flags hold until reset; the FSM keeps running after either flag is set.
- Reset asserted mid-instruction: immediate return to IDLE, all outputs 0 in the same cycle.

Test Plan:
- Reset release, opcode=000000, mem_ready=1 -> states 0,1,2,7,8,1. alu_op=10 in EXECUTE; reg_write=1 and reg_dst=1 in ALU_WB; instr_count=1.
- lw (100011), mem_ready low 3 cycles in MEM_READ -> MEM_READ held 4 cycles with mem_read=1, i_or_d=1. Then MEM_WB with mem_to_reg=1, reg_write=1. Total 8 cycles; instr_count +1.
- beq (000100) -> BRANCH: alu_op=01, alu_src_b=00, pc_write_cond=1, pc_source=01. j (000010) -> JUMP: pc_write=1, pc_source=10. Each 3 cycles.
- opcode=111111 -> DECODE then FETCH. illegal_op=1 from the next cycle and held; instr_count unchanged.
- WAIT_LIMIT=15, mem_ready=0 in FETCH -> ir_write never asserts. bus_error=1 after 15 wait cycles; state re-enters FETCH with the counter cleared.
- rst_n pulsed low during MEM_WRITE -> mem_write=0 immediately, state_out=0, instr_count=0, flags cleared.
